// File: rtl/lpc_capture_sched_if.sv
// lpc_capture_sched_if: capture strobe input and drain handshake between the LPC capture path and the SoC drain logic
interface lpc_capture_sched_if;
  logic [31:0] i_tdata;
  logic        i_ready;
  logic        o_tvalid;
  logic [31:0] o_tdata;
  logic        i_tready;
  modport slave (input i_tdata, i_ready, i_tready, output o_tvalid, o_tdata);
  modport master(output i_tdata, i_ready, i_tready, input o_tvalid, o_tdata);
endinterface

// File: rtl/lpc_capture_sched.sv
// lpc_capture_sched: filters captured LPC I/O cycles, buffers them in a FIFO and schedules a drain interrupt
module lpc_capture_sched #(
  parameter int DEPTH      = 8,
  parameter int LVL_W      = 4,
  parameter int IRQ_THRESH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 lpc_lclk,
  input  logic                 lpc_lreset_n,
  lpc_capture_sched_if.slave   bus,
  input  logic                 i_cfg_en,
  input  logic [15:0]          i_cfg_addr_lo,
  input  logic [15:0]          i_cfg_addr_hi,
  input  logic [1:0]           i_cfg_type_mask,
  input  logic                 i_flush,
  input  logic                 i_clr_ovf,
  output logic [LVL_W-1:0]     o_level,
  output logic                 o_irq,
  output logic                 o_ovf,
  output logic [7:0]           o_ovf_cnt,
  output logic [1:0]           o_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_EMPTY = 2'b00, S_FILL = 2'b01, S_IRQ = 2'b10} state_t;
  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [LVL_W-1:0] r_level, w_level_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  state_t           r_state, w_state_nxt;
  logic             r_irq, r_ovf;
  logic [7:0]       r_ovf_cnt;
  logic [15:0]      w_addr;
  logic [1:0]       w_type;
  logic             w_acc, w_full, w_pop, w_push, w_drop;
  assign w_addr = bus.i_tdata[27:12];
  assign w_type = bus.i_tdata[1:0];
  assign w_acc = bus.i_ready & i_cfg_en & (w_addr >= i_cfg_addr_lo) & (w_addr <= i_cfg_addr_hi) &
                 ((w_type == 2'b01 & i_cfg_type_mask[0]) | (w_type == 2'b11 & i_cfg_type_mask[1]));
  assign w_full = r_level == LVL_W'(DEPTH);
  assign w_pop = bus.o_tvalid & bus.i_tready;
  // a pop in the same cycle frees the slot, so a full FIFO still takes the word
  assign w_push = w_acc & ~i_flush & (~w_full | w_pop);
  assign w_drop = w_acc & ~i_flush & w_full & ~w_pop;
  assign w_level_nxt = i_flush ? '0 :
                       (w_push & ~w_pop) ? r_level + 1'b1 :
                       (~w_push & w_pop) ? r_level - 1'b1 : r_level;
  assign bus.o_tvalid = r_level != '0;
  assign bus.o_tdata  = bus.o_tvalid ? r_mem[r_rd] : '0;
  assign o_level   = r_level;
  assign o_irq     = r_irq;
  assign o_ovf     = r_ovf;
  assign o_ovf_cnt = r_ovf_cnt;
  assign o_state   = r_state;
  // storage array; contents are only visible through a valid head so it needs no reset
  always_ff @(posedge lpc_lclk)
    if (w_push) r_mem[r_wr] <= bus.i_tdata;
  // read/write pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n)
    if (!lpc_lreset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      r_wr    <= i_flush ? '0 : r_wr + PTR_W'(w_push);
      r_rd    <= i_flush ? '0 : r_rd + PTR_W'(w_pop);
      r_level <= w_level_nxt;
    end
  // sticky overflow flag and saturating drop counter; a drop in the clear cycle still counts
  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n)
    if (!lpc_lreset_n) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (i_clr_ovf) begin
      r_ovf     <= w_drop;
      r_ovf_cnt <= {7'd0, w_drop};
    end else if (w_drop) begin
      r_ovf     <= 1'b1;
      r_ovf_cnt <= r_ovf_cnt + {7'd0, r_ovf_cnt != 8'hFF};
    end
  // scheduler next state on the post-update level; idle counter runs only while filling
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    if (i_flush) w_state_nxt = S_EMPTY;
    else
      case (r_state)
        S_EMPTY: w_state_nxt = w_level_nxt >= LVL_W'(IRQ_THRESH) ? S_IRQ :
                               w_level_nxt != '0 ? S_FILL : S_EMPTY;
        S_FILL: begin
          w_cnt_nxt   = w_push ? '0 : r_cnt + 1'b1;
          w_state_nxt = w_level_nxt == '0 ? S_EMPTY :
                        (w_level_nxt >= LVL_W'(IRQ_THRESH) || (!w_push && r_cnt == CNT_W'(TIMEOUT - 1))) ? S_IRQ : S_FILL;
        end
        S_IRQ:   w_state_nxt = w_level_nxt == '0 ? S_EMPTY : S_IRQ;
        default: w_state_nxt = S_EMPTY;
      endcase
  end
  // scheduler state, idle counter and registered interrupt
  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n)
    if (!lpc_lreset_n) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_irq   <= w_state_nxt == S_IRQ;
    end
endmodule

// File: tb/tb_lpc_capture_sched.sv
// tb_lpc_capture_sched: directed and randomized checks of lpc_capture_sched against a queue-based model
module tb_lpc_capture_sched;
  localparam int DEPTH = 8, LVL_W = 4, TH = 4, TO = 40;
  logic clk = 0, rst_n = 0;
  always #15 clk = ~clk;
  logic en = 0, flush = 0, clr = 0;
  logic [15:0] lo = 0, hi = 0;
  logic [1:0] mask = 0;
  logic [LVL_W-1:0] level;
  logic irq, ovf;
  logic [7:0] ovf_cnt;
  logic [1:0] st;
  lpc_capture_sched_if bus();
  lpc_capture_sched #(.DEPTH(DEPTH), .LVL_W(LVL_W), .IRQ_THRESH(TH), .TIMEOUT(TO)) u_dut (
    .lpc_lclk(clk), .lpc_lreset_n(rst_n), .bus(bus),
    .i_cfg_en(en), .i_cfg_addr_lo(lo), .i_cfg_addr_hi(hi), .i_cfg_type_mask(mask),
    .i_flush(flush), .i_clr_ovf(clr),
    .o_level(level), .o_irq(irq), .o_ovf(ovf), .o_ovf_cnt(ovf_cnt), .o_state(st));
  int total = 0, bad = 0;
  logic [31:0] m_q[$];
  logic [31:0] sent[$];
  bit m_ovf;
  int m_cnt, m_st, m_idle;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit accept();
    int a = int'(bus.i_tdata[27:12]);
    int t = int'(bus.i_tdata[1:0]);
    return bus.i_ready && en && a >= int'(lo) && a <= int'(hi) &&
           ((t == 1 && mask[0]) || (t == 3 && mask[1]));
  endfunction
  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_cnt = 0;
    m_st = 0;
    m_idle = 0;
  endtask
  task automatic model_step();
    bit acc = accept();
    bit pop = m_q.size() != 0 && bus.i_tready;
    bit push = 0, ov = 0;
    int n;
    if (flush) begin
      m_q.delete();
      m_st = 0;
      m_idle = 0;
    end else begin
      ov = acc && m_q.size() == DEPTH && !pop;
      if (pop) void'(m_q.pop_front());
      if (acc && !ov) begin
        m_q.push_back(bus.i_tdata);
        push = 1;
      end
      n = m_q.size();
      if (m_st == 0) begin
        if (n >= TH) m_st = 2;
        else if (n > 0) begin m_st = 1; m_idle = 0; end
      end else if (m_st == 1) begin
        m_idle = push ? 0 : m_idle + 1;
        if (n == 0) m_st = 0;
        else if (n >= TH || m_idle >= TO) m_st = 2;
      end else if (n == 0) m_st = 0;
    end
    if (clr) begin
      m_ovf = ov;
      m_cnt = ov ? 1 : 0;
    end else if (ov) begin
      m_ovf = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask
  task automatic check_all();
    chk("tvalid", 32'(bus.o_tvalid), 32'(m_q.size() != 0));
    chk("tdata", bus.o_tdata, m_q.size() != 0 ? m_q[0] : 32'h0);
    chk("level", 32'(level), 32'(m_q.size()));
    chk("irq", 32'(irq), 32'(m_st == 2));
    chk("state", 32'(st), 32'(m_st));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    check_all();
  endtask
  task automatic strobe(input logic [15:0] a, input logic [1:0] t);
    bus.i_tdata = {4'($urandom), a, 8'($urandom), 2'($urandom), t};
    sent.push_back(bus.i_tdata);
    bus.i_ready = 1;
    tick();
    bus.i_ready = 0;
  endtask
  task automatic drain();
    bus.i_tready = 1;
    repeat (DEPTH + 1) tick();
    bus.i_tready = 0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(bus.o_tvalid), 0);
    chk({tag, "_tdata"}, bus.o_tdata, 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 0);
    chk({tag, "_state"}, 32'(st), 0);
  endtask
  initial begin
    int n, pr, rp;
    bus.i_tdata = 0;
    bus.i_ready = 0;
    bus.i_tready = 0;
    model_reset();
    #50;
    chk_reset_outputs("rst");
    rst_n = 1;
    en = 1; lo = 16'h0080; hi = 16'h008F; mask = 2'b11;
    tick();
    strobe(16'h007F, 2'b01);
    chk("filt_reject_lo", 32'(level), 0);
    strobe(16'h0080, 2'b01);
    chk("filt_tvalid_lat", 32'(bus.o_tvalid), 1);
    strobe(16'h008F, 2'b11);
    strobe(16'h0090, 2'b01);
    chk("filt_level", 32'(level), 2);
    drain();
    mask = 2'b01;
    strobe(16'h0080, 2'b11);
    strobe(16'h0080, 2'b01);
    chk("mask_level", 32'(level), 1);
    chk("mask_type", 32'(bus.o_tdata[1:0]), 1);
    mask = 2'b11;
    strobe(16'h0080, 2'b00);
    chk("type00_level", 32'(level), 1);
    drain();
    sent.delete();
    for (int i = 0; i < 4; i++) begin
      chk("thr_irq_low", 32'(irq), 0);
      strobe(16'h0081 + 16'(i), 2'b01);
    end
    chk("thr_irq", 32'(irq), 1);
    bus.i_tready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("thr_order", bus.o_tdata, sent[i]);
      tick();
    end
    bus.i_tready = 0;
    chk("thr_level0", 32'(level), 0);
    chk("thr_irq_off", 32'(irq), 0);
    chk("thr_state", 32'(st), 0);
    strobe(16'h0085, 2'b01);
    n = 0;
    while (!irq && n < 2 * TO) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TO));
    chk("timeout_state", 32'(st), 2);
    drain();
    sent.delete();
    for (int i = 0; i < 10; i++) strobe(16'h0080 + 16'(i), 2'b01);
    chk("ovf_level", 32'(level), 8);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_cnt", 32'(ovf_cnt), 2);
    chk("ovf_head", bus.o_tdata, sent[0]);
    bus.i_tready = 1;
    strobe(16'h008A, 2'b11);
    bus.i_tready = 0;
    chk("full_pp_level", 32'(level), 8);
    chk("full_pp_cnt", 32'(ovf_cnt), 2);
    chk("full_pp_head", bus.o_tdata, sent[1]);
    bus.i_tready = 1;
    repeat (3) tick();
    bus.i_tready = 0;
    chk("pre_flush_level", 32'(level), 5);
    chk("pre_flush_irq", 32'(irq), 1);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_level", 32'(level), 0);
    chk("flush_irq", 32'(irq), 0);
    chk("flush_cnt", 32'(ovf_cnt), 2);
    clr = 1;
    tick();
    clr = 0;
    chk("clr_cnt", 32'(ovf_cnt), 0);
    chk("clr_flag", 32'(ovf), 0);
    for (int i = 0; i < 5; i++) strobe(16'h0088, 2'b01);
    bus.i_tready = 1;
    repeat (2) tick();
    #5;
    rst_n = 0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    bus.i_tready = 0;
    tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < 4000; i++) begin
      if (i == 1500) begin lo = 16'h0090; hi = 16'h0080; end
      if (i == 2000) begin lo = 16'h0080; hi = 16'h008F; end
      if ($urandom_range(0, 19) == 0) mask = 2'($urandom);
      en = $urandom_range(0, 19) != 0;
      case ((i / 200) % 3)
        0: pr = 10;
        1: pr = 50;
        default: pr = 90;
      endcase
      case ((i / 300) % 4)
        0: rp = 60;
        1: rp = 30;
        2: rp = 5;
        default: rp = 0;
      endcase
      bus.i_tready = $urandom_range(0, 99) < pr;
      bus.i_ready = $urandom_range(0, 99) < rp;
      bus.i_tdata = {4'($urandom), 16'h0078 + 16'($urandom_range(0, 31)), 10'($urandom), 2'($urandom)};
      flush = $urandom_range(0, 49) == 0;
      clr = $urandom_range(0, 29) == 0;
      tick();
    end
    bus.i_ready = 0;
    flush = 0;
    clr = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lpc_capture_sched.md
Name: lpc_capture_sched

Overview:
- Sits between the LPC peripheral's captured-cycle output (32-bit cycle word plus 1-cycle valid pulse) and the SoC-side drain logic.
- Filters captured I/O cycles by address window and cycle type, then buffers accepted words in a FIFO.
- Drains the FIFO through a valid/ready handshake and schedules an interrupt on a fill threshold or an idle timeout.
- Counts words dropped on overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- LVL_W, 4, level width; equals log2(DEPTH)+1.
- IRQ_THRESH, 4, level at or above which the IRQ is raised immediately; range 1..DEPTH.
- TIMEOUT, 1024, lpc_lclk cycles after the last accepted push before a non-empty, below-threshold FIFO raises the IRQ.

Ports:
- lpc_lclk  in  1  LPC clock, 33 MHz; the only clock.
- lpc_lreset_n  in  1  asynchronous active-low reset.
- i_tdata  in  32  captured cycle word: [27:12] address, [11:4] data, [1:0] type (01 write, 11 read).
- i_ready  in  1  one-cycle strobe marking i_tdata valid.
- i_cfg_en  in  1  capture enable; 0 rejects all strobes.
- i_cfg_addr_lo  in  16  inclusive lower address bound.
- i_cfg_addr_hi  in  16  inclusive upper address bound.
- i_cfg_type_mask  in  2  bit0 accepts writes, bit1 accepts reads.
- i_flush  in  1  synchronous FIFO clear.
- i_clr_ovf  in  1  clears overflow counter and flag.
- o_tvalid  out  1  FIFO head valid.
- o_tdata  out  32  FIFO head word.
- i_tready  in  1  consumer accepts head.
- o_level  out  LVL_W  current occupancy.
- o_irq  out  1  service request, level-sensitive.
- o_ovf  out  1  sticky overflow flag.
- o_ovf_cnt  out  8  dropped-word count, saturating.
- o_state  out  2  scheduler state (00 EMPTY, 01 FILL, 10 IRQ).

Behaviour:
- Reset (async, lpc_lreset_n=0): FIFO empty, pointers 0, o_tvalid=0, o_tdata=0, o_level=0, o_irq=0, o_ovf=0, o_ovf_cnt=0, timeout counter 0, state EMPTY. Reset mid-transfer discards all content.
- Accept condition, evaluated combinationally in the strobe cycle: i_ready & i_cfg_en & lo<=addr<=hi & type allowed.
  - Type allowed means type==01 with mask[0], or type==11 with mask[1].
  - Types 00 and 10 are always rejected.
  - If lo>hi, nothing is accepted.
  - Config changes take effect on the next strobe only.
- Push: an accepted word is written at the write pointer on the clock edge and the pointer wraps modulo DEPTH.
  - o_tvalid rises on the cycle after the push edge; latency 1.
- Pop: occurs when o_tvalid & i_tready; the read pointer advances.
  - o_tdata is the head entry, valid whenever o_tvalid=1, and holds while i_tready=0.
  - o_tvalid = (o_level != 0).
- Simultaneous push and pop: o_level unchanged; when full, the push is accepted because the pop frees the slot.
  - Push into an empty FIFO cannot be popped in the same cycle.
- Overflow: an accepted push while full without a pop is dropped.
  - o_ovf is set; o_ovf_cnt increments and saturates at 255.
  - FIFO contents are unchanged.
- i_clr_ovf zeroes o_ovf and o_ovf_cnt. If an overflow occurs in the same cycle, the result is o_ovf=1 and o_ovf_cnt=1.
- i_flush empties the FIFO, clears the timeout counter and moves the state to EMPTY.
  - A push in the same cycle is discarded.
  - The overflow counter is not affected.
- Scheduler FSM, evaluated on post-update level:
  - EMPTY: if level>=IRQ_THRESH, go to IRQ; if level>0, go to FILL.
  - FILL: timeout counter clears on every accepted push, otherwise increments.
    - Go to IRQ when level>=IRQ_THRESH or the counter reaches TIMEOUT-1.
    - Go to EMPTY when level==0.
  - IRQ: o_irq=1 and stays asserted until level==0, then go to EMPTY. Pushes do not deassert it.
  - o_irq is registered and equals (state==IRQ).
- Level arithmetic is unsigned LVL_W bits; level never exceeds DEPTH and never underflows.

Test Plan:
- Filter window: lo=0x0080, hi=0x008F, mask=11, strobes on addresses 0x007F, 0x0080, 0x008F, 0x0090 -> only the 0x0080 and 0x008F words buffered; o_level=2, o_tvalid=1 one cycle after the first accepted push.
- Type mask: mask=01, strobe a read (type 11) and a write (type 01) to 0x0080 -> one entry, o_tdata[1:0]=01; a type-00 strobe -> no change.
- Threshold IRQ: i_tready=0, push 4 words -> o_irq=1 on the cycle after the 4th push; pop all with i_tready=1 -> words come out in order, o_irq=0 after level reaches 0, o_state=00.
- Timeout IRQ: push 1 word then idle -> o_irq asserts exactly TIMEOUT cycles after the push, o_state=10.
- Overflow: push 10 words with i_tready=0 -> o_level=8, o_ovf=1, o_ovf_cnt=2, head equals the 1st word.
  - Then push and pop simultaneously while full -> push accepted, o_level stays 8, o_ovf_cnt stays 2.
  - Then i_clr_ovf -> o_ovf_cnt=0.
- Reset and flush: deassert lpc_lreset_n mid-drain -> all outputs return to reset values immediately; i_flush with o_level=5 and o_irq=1 -> o_level=0, o_irq=0, o_ovf_cnt unchanged.
